pipe_fp_adder: RTL and testbench

Pipelined, parametrised floating-point adder/subtractor; the sequential successor to the combinational single-precision summator in the basic-arithmetic set. It accepts operand pairs through a valid/ready handshake, produces a rounded IEEE-754-style result and a status code three cycles later, and stalls cleanly under output backpressure. Format width is set by parameters, so one block covers binary16, binary32 and custom formats.

---
 rtl/pipe_fp_adder.sv | 222 ++++++++++++++++++++++
 tb/tb_pipe_fp_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fp_adder.sv
// pipe_fp_adder
//   Three-stage pipelined floating-point adder/subtractor with a parametrised
//   format {sign, exp[EXP_W], mant[MANT_W]} (hidden bit not stored).
//   Stage 1 aligns, stage 2 adds/subtracts, stage 3 normalises, rounds and
//   resolves special cases into the registered outputs.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   vld_i / rdy_o    operand handshake (a_i, b_i, sub_i)
//   sub_i            0: a+b, 1: a-b
//   a_i, b_i         operands
//   vld_o / rdy_i    result handshake (answer_o, answer_status_o)
//   answer_o         result
//   answer_status_o  00 normal/zero, 01 overflow, 10 underflow, 11 NaN
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// whole pipe advances when the output slot is empty or being taken
// (advance = !vld_o || rdy_i), and rdy_o is that advance term, so rdy_o is
// combinational on rdy_i. While stalled every stage and the outputs hold.
//
// Configuration macro FP_ADD_RNE_EN
//   defined   : round to nearest, ties to even; overflow gives +-inf
//   undefined : truncation; overflow saturates to +-max finite
module pipe_fp_adder #(
   parameter  int EXP_W  = 8,
   parameter  int MANT_W = 23,
   localparam int W      = 1 + EXP_W + MANT_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         vld_i,
   output logic         rdy_o,
   input  logic         sub_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         vld_o,
   input  logic         rdy_i,
   output logic [W-1:0] answer_o,
   output logic [1:0]   answer_status_o
);
   // significand plus hidden bit plus guard/round/sticky
   localparam int EXT_W = MANT_W + 4;
   // working exponent wide enough for +2 and for -EXT_W without wrapping
   localparam int LZ_W  = $clog2(EXT_W) + 1;
   localparam int EW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

   logic advance;
   assign advance = !vld_o || rdy_i;
   assign rdy_o   = advance;

   // ---------------- stage 1: unpack, classify, swap, align ----------------
   logic                  a_s, b_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [EXP_W-1:0]      a_e, b_e, big_e, small_e, diff;
   logic [MANT_W-1:0]     a_m, b_m;
   logic [W-2:0]          a_mag, b_mag;
   logic [MANT_W:0]       a_sig, b_sig, big_sig, small_sig;
   logic [EXT_W-1:0]      small_ext, mask, small_al;
   logic                  big_s, small_s, nan_c, inf_c;
   logic [W-1:0]          spc_res;

   assign a_s    = a_i[W-1];
   assign b_s    = b_i[W-1] ^ sub_i;
   assign a_e    = a_i[W-2:MANT_W];
   assign b_e    = b_i[W-2:MANT_W];
   assign a_m    = a_i[MANT_W-1:0];
   assign b_m    = b_i[MANT_W-1:0];
   // subnormals (exp == 0) are treated as zero
   assign a_zero = (a_e == '0);
   assign b_zero = (b_e == '0);
   assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
   assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
   assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
   assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
   assign a_mag  = a_zero ? '0 : a_i[W-2:0];
   assign b_mag  = b_zero ? '0 : b_i[W-2:0];
   assign a_sig  = a_zero ? '0 : {1'b1, a_m};
   assign b_sig  = b_zero ? '0 : {1'b1, b_m};
   assign swap   = (b_mag > a_mag);
   assign nan_c  = a_nan || b_nan || (a_inf && b_inf && (a_s != b_s));
   assign inf_c  = a_inf || b_inf;

   always_comb begin
      big_s     = swap ? b_s   : a_s;
      small_s   = swap ? a_s   : b_s;
      big_e     = swap ? b_e   : a_e;
      small_e   = swap ? a_e   : b_e;
      big_sig   = swap ? b_sig : a_sig;
      small_sig = swap ? a_sig : b_sig;
      diff      = big_e - small_e;
      small_ext = {small_sig, 3'b000};
      mask      = ~({EXT_W{1'b1}} << diff);
      if (32'(diff) >= 32'(MANT_W + 3))
         small_al = {{(EXT_W-1){1'b0}}, |small_sig};
      else
         small_al = (small_ext >> diff) | {{(EXT_W-1){1'b0}}, |(small_ext & mask)};
      if (nan_c)
         spc_res = QNAN;
      else
         spc_res = {(a_inf ? a_s : b_s), EXP_ONES, {MANT_W{1'b0}}};
   end

   logic             s1_vld, s1_sign, s1_sub, s1_spc;
   logic [EXP_W-1:0] s1_exp;
   logic [EXT_W-1:0] s1_big, s1_small;
   logic [W-1:0]     s1_spc_res;
   logic [1:0]       s1_spc_st;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_vld <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_spc <= 1'b0;
         s1_exp <= '0; s1_big <= '0; s1_small <= '0;
         s1_spc_res <= '0; s1_spc_st <= 2'b00;
      end else if (advance) begin
         s1_vld     <= vld_i;
         s1_sign    <= big_s;
         s1_sub     <= big_s ^ small_s;
         s1_spc     <= nan_c || inf_c;
         s1_exp     <= big_e;
         s1_big     <= {big_sig, 3'b000};
         s1_small   <= small_al;
         s1_spc_res <= spc_res;
         s1_spc_st  <= nan_c ? 2'b11 : 2'b00;
      end
   end

   // ---------------- stage 2: add / subtract magnitudes ----------------
   // |big| >= |small| after the swap, so the difference never goes negative
   logic             s2_vld, s2_sign, s2_sub, s2_spc;
   logic [EXP_W-1:0] s2_exp;
   logic [EXT_W:0]   s2_sum;
   logic [W-1:0]     s2_spc_res;
   logic [1:0]       s2_spc_st;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_vld <= 1'b0; s2_sign <= 1'b0; s2_sub <= 1'b0; s2_spc <= 1'b0;
         s2_exp <= '0; s2_sum <= '0; s2_spc_res <= '0; s2_spc_st <= 2'b00;
      end else if (advance) begin
         s2_vld     <= s1_vld;
         s2_sign    <= s1_sign;
         s2_sub     <= s1_sub;
         s2_spc     <= s1_spc;
         s2_exp     <= s1_exp;
         s2_sum     <= s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                              : ({1'b0, s1_big} + {1'b0, s1_small});
         s2_spc_res <= s1_spc_res;
         s2_spc_st  <= s1_spc_st;
      end
   end

   // ---------------- stage 3: normalise, round, classify ----------------
   int                lz;
   logic [EXT_W-1:0]  norm;
   logic [EW-1:0]     exp_n, exp_r;
   logic [MANT_W+1:0] sig_t, sig_r;
   logic [MANT_W-1:0] mant_r;
   logic [W-1:0]      res;
   logic [1:0]        res_st;

   always_comb begin
      lz = 0;
      for (int i = 0; i < EXT_W; i++)
         if (s2_sum[i]) lz = EXT_W - 1 - i;
      if (s2_sum[EXT_W]) begin
         // carry out: shift right one, folding the lost bit into sticky
         norm  = {s2_sum[EXT_W:2], s2_sum[1] | s2_sum[0]};
         exp_n = EW'(s2_exp) + EW'(1);
      end else begin
         norm  = s2_sum[EXT_W-1:0] << lz;
         exp_n = EW'(s2_exp) - EW'(lz);
      end
      sig_t = (MANT_W+2)'({1'b0, norm} >> 3);
`ifdef FP_ADD_RNE_EN
      // round up when above half, or exactly half with an odd LSB
      sig_r = sig_t + (MANT_W+2)'(norm[2] & (norm[1] | norm[0] | norm[3]));
`else
      sig_r = sig_t;
`endif
      if (sig_r[MANT_W+1]) begin
         exp_r  = exp_n + EW'(1);
         mant_r = sig_r[MANT_W:1];
      end else begin
         exp_r  = exp_n;
         mant_r = sig_r[MANT_W-1:0];
      end
      res    = {s2_sign, exp_r[EXP_W-1:0], mant_r};
      res_st = 2'b00;
      if (s2_spc) begin
         res    = s2_spc_res;
         res_st = s2_spc_st;
      end else if (s2_sum == '0) begin
         // exact cancellation is +0; adding two zeros keeps their sign
         res = {(s2_sub ? 1'b0 : s2_sign), {(W-1){1'b0}}};
      end else if (!exp_r[EW-1] && (exp_r >= EW'(EXP_ONES))) begin
`ifdef FP_ADD_RNE_EN
         res = {s2_sign, EXP_ONES, {MANT_W{1'b0}}};
`else
         res = {s2_sign, EXP_ONES - EXP_W'(1), {MANT_W{1'b1}}};
`endif
         res_st = 2'b01;
      end else if (exp_r[EW-1] || (exp_r == '0)) begin
         res    = {s2_sign, {(W-1){1'b0}}};
         res_st = 2'b10;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_o           <= 1'b0;
         answer_o        <= '0;
         answer_status_o <= 2'b00;
      end else if (advance) begin
         vld_o           <= s2_vld;
         answer_o        <= res;
         answer_status_o <= res_st;
      end
   end

endmodule

// File: tb/tb_pipe_fp_adder.sv
module tb_pipe_fp_adder;
   localparam int W  = 32;
   localparam int NV = 17;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic         vld_i = 1'b0, sub_i = 1'b0, rdy_i = 1'b1;
   logic [W-1:0] a_i = '0, b_i = '0;
   logic         rdy_o, vld_o;
   logic [W-1:0] answer;
   logic [1:0]   status;

   logic         h_vld = 1'b0, h_sub = 1'b0, h_rdy = 1'b1;
   logic [15:0]  h_a = '0, h_b = '0;
   logic         h_rdy_o, h_vld_o;
   logic [15:0]  h_ans;
   logic [1:0]   h_st;

   pipe_fp_adder dut (
      .clk_i(clk), .rst_ni(rst_n), .vld_i(vld_i), .rdy_o(rdy_o), .sub_i(sub_i),
      .a_i(a_i), .b_i(b_i), .vld_o(vld_o), .rdy_i(rdy_i),
      .answer_o(answer), .answer_status_o(status)
   );

   pipe_fp_adder #(.EXP_W(5), .MANT_W(10)) dut_h (
      .clk_i(clk), .rst_ni(rst_n), .vld_i(h_vld), .rdy_o(h_rdy_o), .sub_i(h_sub),
      .a_i(h_a), .b_i(h_b), .vld_o(h_vld_o), .rdy_i(h_rdy),
      .answer_o(h_ans), .answer_status_o(h_st)
   );

   // ---------------- vector table with hand-derived results ----------------
`ifdef FP_ADD_RNE_EN
   localparam logic [W-1:0] R1 = 32'h3F800001, R3 = 32'h7F800000;
   localparam logic [W-1:0] R13 = 32'h3F800002, R14 = 32'h3F800000;
`else
   localparam logic [W-1:0] R1 = 32'h3F800000, R3 = 32'h7F7FFFFF;
   localparam logic [W-1:0] R13 = 32'h3F800001, R14 = 32'h3F7FFFFF;
`endif
   logic [W-1:0] va [NV] = '{32'h3F600000, 32'h3F800000, 32'h40400000, 32'h7F7FFFFF,
                             32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h40000000,
                             32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h00800000,
                             32'h00000001, 32'h3F800001, 32'h3F800000, 32'h80000000,
                             32'h3FC00000};
   logic [W-1:0] vb [NV] = '{32'h400CCCCD, 32'h33C00000, 32'h40400000, 32'h7F7FFFFF,
                             32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000,
                             32'hC0000000, 32'h3F800000, 32'h7F800000, 32'h00C00000,
                             32'h3F800000, 32'h33800000, 32'h0D800000, 32'h80000000,
                             32'h3F000000};
   logic         vs [NV] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0};
   logic [W-1:0] vr [NV] = '{32'h4044CCCD, R1, 32'h00000000, R3,
                             32'h7FC00000, 32'h7FC00000, 32'h40000000, 32'h3F800000,
                             32'hBF800000, 32'h7F800000, 32'hFF800000, 32'h80000000,
                             32'h3F800000, R13, R14, 32'h80000000,
                             32'h40000000};
   logic [1:0]   vst [NV] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b00};

   // ---------------- scoreboard ----------------
   logic [W+1:0] exp_q[$];
   int           cyc_q[$];
   bit           lat_q[$];
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input int idx, input bit chk_lat);
      int waited = 0;
      bit done = 0;
      vld_i = 1'b1; a_i = va[idx]; b_i = vb[idx]; sub_i = vs[idx];
      while (!done) begin
         @(negedge clk);
         if (rdy_o) begin
            exp_q.push_back({vst[idx], vr[idx]});
            cyc_q.push_back(cyc);
            lat_q.push_back(chk_lat);
            done = 1;
         end else if (++waited > 50) begin
            chk("drive_timeout", 64'(waited), 64'(50));
            done = 1;
         end
         @(posedge clk); #2;
      end
      vld_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(posedge clk); #2;
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   // ---------------- monitor ----------------
   initial begin : mon
      logic [W+1:0] e, held_val;
      int           c;
      bit           l, held;
      held = 0;
      held_val = '0;
      forever begin
         @(negedge clk);
         if (vld_o && rst_n) begin
            if (!rdy_i) begin
               chk("rdy_o_stall", 64'(rdy_o), 64'(0));
               if (held) chk("hold_stable", 64'({status, answer}), 64'(held_val));
               held = 1;
               held_val = {status, answer};
            end else begin
               held = 0;
               if (exp_q.size() == 0) begin
                  chk("spurious_result", 64'(vld_o), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  c = cyc_q.pop_front();
                  l = lat_q.pop_front();
                  chk("result", 64'({status, answer}), 64'(e));
                  if (l) chk("latency", 64'(cyc - c), 64'(3));
               end
            end
         end else begin
            held = 0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "simulation did not finish");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int waited;
      #1;
      chk("reset_vld_o", 64'(vld_o), 64'(0));
      chk("reset_answer", 64'(answer), 64'(0));
      chk("reset_status", 64'(status), 64'(0));
      chk("reset_h_vld_o", 64'(h_vld_o), 64'(0));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("release_rdy_o", 64'(rdy_o), 64'(1));

      // directed vectors back to back, latency checked on each
      for (int i = 0; i < NV; i++) drive(i, 1'b1);
      drain();

      // five back-to-back pairs with the sink stalled for four cycles
      fork
         begin
            for (int k = 0; k < 5; k++) drive(k, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #2 rdy_i = 1'b0;
            repeat (4) @(posedge clk);
            #2 rdy_i = 1'b1;
         end
      join
      drain();

      // random picks from the table under random backpressure
      fork
         begin
            for (int n = 0; n < 40; n++) drive(int'($urandom_range(0, NV - 1)), 1'b0);
         end
         begin
            for (int n = 0; n < 60; n++) begin
               @(posedge clk);
               #2 rdy_i = ($urandom_range(0, 3) != 0);
            end
            rdy_i = 1'b1;
         end
      join
      rdy_i = 1'b1;
      drain();

      // reset with operations in flight: nothing may emerge afterwards
      drive(6, 1'b0);
      drive(7, 1'b0);
      drive(0, 1'b0);
      chk("pre_reset_vld_o", 64'(vld_o), 64'(1));
      rst_n = 1'b0;
      exp_q.delete();
      cyc_q.delete();
      lat_q.delete();
      #1;
      chk("async_reset_vld_o", 64'(vld_o), 64'(0));
      chk("async_reset_answer", 64'(answer), 64'(0));
      chk("async_reset_status", 64'(status), 64'(0));
      chk("async_reset_rdy_o", 64'(rdy_o), 64'(1));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #2 chk("post_reset_vld_o", 64'(vld_o), 64'(0));
      drive(0, 1'b1);
      drain();

      // half-precision instance: 1+1 with a held output, then 1-2
      h_a = 16'h3C00; h_b = 16'h3C00; h_sub = 1'b0; h_rdy = 1'b0; h_vld = 1'b1;
      @(negedge clk);
      chk("h_rdy_o_idle", 64'(h_rdy_o), 64'(1));
      @(posedge clk);
      #2 h_vld = 1'b0;
      waited = 0;
      while (!h_vld_o && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("h_latency", 64'(waited), 64'(3));
      chk("h_answer_add", 64'(h_ans), 64'(16'h4000));
      chk("h_status_add", 64'(h_st), 64'(0));
      chk("h_rdy_o_stall", 64'(h_rdy_o), 64'(0));
      repeat (2) @(negedge clk);
      chk("h_hold_vld", 64'(h_vld_o), 64'(1));
      chk("h_hold_answer", 64'(h_ans), 64'(16'h4000));
      @(posedge clk);
      #2 h_rdy = 1'b1;
      repeat (2) @(negedge clk);
      chk("h_vld_o_taken", 64'(h_vld_o), 64'(0));

      h_a = 16'h3C00; h_b = 16'h4000; h_sub = 1'b1; h_vld = 1'b1;
      @(posedge clk);
      #2 h_vld = 1'b0;
      waited = 0;
      while (!h_vld_o && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("h_answer_sub", 64'(h_ans), 64'(16'hBC00));
      chk("h_status_sub", 64'(h_st), 64'(0));
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
